lcd_reader: RTL and testbench

Read-side companion to the LCD write controller for the HD44780-compatible character LCD on the 4-bit interface. On request, it performs one 8-bit read, either the busy flag plus address counter (RS=0) or DDRAM/CGRAM data (RS=1), as two nibble reads with RW=1. It returns the assembled byte with a one-cycle valid strobe. It sits beside the write controller; a top-level mux grants pad ownership, and the reader drives the shared pads only while its own ready output is low.

---
 rtl/lcd_reader.sv | 193 +++++++++++++++++++
 tb/tb_lcd_reader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lcd_reader.sv
// lcd_reader: read-side sequencer for an HD44780-compatible character LCD on the 4-bit bus.
//
// A request performs one 8-bit read as two nibble accesses with RW=1: busy flag plus address
// counter when the latched RS is 0, DDRAM/CGRAM data when it is 1. The assembled byte is
// presented on oData together with a one-cycle oValid pulse.
//
// The reader never drives DB7..DB4 (oLCD_DataDrive is tied low). An external mux hands the
// shared pads to this block while ready is low.
//
// Ports:
//   Clock          system clock (50 MHz nominal)
//   Reset          synchronous, active-high
//   iRead          read request, sampled only while ready=1
//   iRS            register select for the request (0=busy/address, 1=data)
//   iLCD_Data      DB7..DB4 pads as inputs
//   oLCD_Enabled   E strobe
//   oLCD_RS        RS pad
//   oLCD_RW        R/W pad, 1=read (always 1 here)
//   oLCD_DataDrive pad output-enable for DB7..DB4 (always 0 here)
//   oData          last byte read, {MSN, LSN}
//   oValid         one-cycle pulse coincident with a freshly loaded oData
//   ready          high in IDLE, a request will be accepted
module lcd_reader #(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned ENABLE_CYCLES = 12,
  parameter int unsigned HOLD_CYCLES   = 1,
  parameter int unsigned GAP_CYCLES    = 50
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iRead,
  input  logic       iRS,
  input  logic [3:0] iLCD_Data,
  output logic       oLCD_Enabled,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic       oLCD_DataDrive,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       ready
);

  // Counter sized for the longest phase, never narrower than 8 bits.
  localparam int unsigned MaxSE  = (SETUP_CYCLES > ENABLE_CYCLES) ? SETUP_CYCLES : ENABLE_CYCLES;
  localparam int unsigned MaxHG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MaxCyc = (MaxSE > MaxHG) ? MaxSE : MaxHG;
  localparam int unsigned CntW   = ($clog2(MaxCyc + 1) > 8) ? $clog2(MaxCyc + 1) : 8;

  // Terminal counts: a phase lasting N cycles ends when the counter reads N-1.
  localparam logic [CntW-1:0] SetupLast  = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] EnableLast = CntW'(ENABLE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast    = CntW'(GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StMsnSetup = 4'd1,
    StMsnEn    = 4'd2,
    StMsnHold  = 4'd3,
    StGap      = 4'd4,
    StLsnSetup = 4'd5,
    StLsnEn    = 4'd6,
    StLsnHold  = 4'd7,
    StDone     = 4'd8
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rs_q, rs_d;
  logic [7:0]      cap_q, cap_d;
  logic [7:0]      data_q, data_d;
  logic            cnt_done;

  // Terminal-count decode for the current phase.
  always_comb begin
    cnt_done = 1'b0;
    case (state_q)
      StMsnSetup, StLsnSetup: cnt_done = (cnt_q == SetupLast);
      StMsnEn, StLsnEn:       cnt_done = (cnt_q == EnableLast);
      StMsnHold, StLsnHold:   cnt_done = (cnt_q == HoldLast);
      StGap:                  cnt_done = (cnt_q == GapLast);
      default:                cnt_done = 1'b0;
    endcase
  end

  // Next-state and output decode.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rs_d           = rs_q;
    cap_d          = cap_q;
    data_d         = data_q;
    oLCD_Enabled   = 1'b0;
    oLCD_RS        = rs_q;
    oLCD_RW        = 1'b1;
    oLCD_DataDrive = 1'b0;
    oValid         = 1'b0;
    ready          = 1'b0;

    case (state_q)
      StIdle: begin
        ready   = 1'b1;
        oLCD_RS = 1'b0;
        if (iRead) begin
          rs_d    = iRS;
          state_d = StMsnSetup;
        end
      end

      StMsnSetup: begin
        if (cnt_done) state_d = StMsnEn;
      end

      StMsnEn: begin
        oLCD_Enabled = 1'b1;
        // Data is only trusted at the very end of the E-high window.
        if (cnt_done) begin
          cap_d[7:4] = iLCD_Data;
          state_d    = StMsnHold;
        end
      end

      StMsnHold: begin
        if (cnt_done) state_d = StGap;
      end

      StGap: begin
        if (cnt_done) state_d = StLsnSetup;
      end

      StLsnSetup: begin
        if (cnt_done) state_d = StLsnEn;
      end

      StLsnEn: begin
        oLCD_Enabled = 1'b1;
        if (cnt_done) begin
          cap_d[3:0] = iLCD_Data;
          state_d    = StLsnHold;
        end
      end

      StLsnHold: begin
        // Load oData on entry to DONE so the byte is valid while oValid is high.
        if (cnt_done) begin
          data_d  = cap_q;
          state_d = StDone;
        end
      end

      StDone: begin
        oValid  = 1'b1;
        state_d = StIdle;
      end

      default: begin
        // Unreachable encodings: recover to IDLE looking exactly like reset.
        state_d = StIdle;
        rs_d    = 1'b0;
        cap_d   = 8'h00;
        data_d  = 8'h00;
        ready   = 1'b1;
        oLCD_RS = 1'b0;
      end
    endcase

    // Single shared counter: restart on any state change, count while a phase runs.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != StIdle) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      cap_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      cap_q   <= cap_d;
      data_q  <= data_d;
    end
  end

  assign oData = data_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader: an LCD read model drives nibbles per cycle, expected bytes
// go into a scoreboard queue when a request is issued and are popped on oValid.
module tb_lcd_reader;

  logic       Clock;
  logic       Reset;
  logic       iRead;
  logic       iRS;
  logic [3:0] iLCD_Data;
  logic       oLCD_Enabled;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic       oLCD_DataDrive;
  logic [7:0] oData;
  logic       oValid;
  logic       ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  lcd_reader dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .iRead          (iRead),
    .iRS            (iRS),
    .iLCD_Data      (iLCD_Data),
    .oLCD_Enabled   (oLCD_Enabled),
    .oLCD_RS        (oLCD_RS),
    .oLCD_RW        (oLCD_RW),
    .oLCD_DataDrive (oLCD_DataDrive),
    .oData          (oData),
    .oValid         (oValid),
    .ready          (ready)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are examined 1 time unit after the edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // One full read starting in an IDLE cycle (cycle 0). Returns in cycle 82 (IDLE).
  //   window:    drive 0xF except the two sampling cycles (14 and 79)
  //   toggle:    randomise iRead/iRS through the GAP phase
  //   keep_read: hold iRead high so the next read chains directly
  task automatic run_txn(input logic rs, input logic [3:0] msn, input logic [3:0] lsn,
                         input bit window, input bit toggle, input bit keep_read);
    logic in_msn;
    logic in_lsn;
    logic in_gap;
    chk1("idle_ready", ready, 1'b1);
    chk1("idle_enable", oLCD_Enabled, 1'b0);
    iRead     = 1'b1;
    iRS       = rs;
    iLCD_Data = window ? 4'hF : 4'($urandom);
    exp_q.push_back({msn, lsn});
    for (int c = 1; c <= 81; c++) begin
      step();
      in_msn = (c >= 3) && (c <= 14);
      in_lsn = (c >= 68) && (c <= 79);
      in_gap = (c >= 16) && (c <= 65);
      if (toggle && in_gap) begin
        iRead = 1'($urandom);
        iRS   = 1'($urandom);
      end else begin
        iRead = keep_read;
        iRS   = rs;
      end
      if (window) iLCD_Data = (c == 14) ? msn : ((c == 79) ? lsn : 4'hF);
      else        iLCD_Data = in_msn ? msn : (in_lsn ? lsn : 4'($urandom));
      chk1("enable", oLCD_Enabled, in_msn || in_lsn);
      chk1("rs", oLCD_RS, rs);
      chk1("rw", oLCD_RW, 1'b1);
      chk1("data_drive", oLCD_DataDrive, 1'b0);
      chk1("busy_ready", ready, 1'b0);
      chk1("valid", oValid, c == 81);
      if (oValid) begin
        chk1("sb_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk8("data", oData, exp_q.pop_front());
      end
    end
    step();
    chk1("post_ready", ready, 1'b1);
    chk1("post_enable", oLCD_Enabled, 1'b0);
    chk1("post_valid", oValid, 1'b0);
    chk1("post_drive", oLCD_DataDrive, 1'b0);
    chk8("post_hold_data", oData, {msn, lsn});
  endtask

  initial begin
    Reset     = 1'b1;
    iRead     = 1'b0;
    iRS       = 1'b0;
    iLCD_Data = 4'h0;
    step();
    chk1("rst_enable", oLCD_Enabled, 1'b0);
    chk1("rst_rs", oLCD_RS, 1'b0);
    chk1("rst_rw", oLCD_RW, 1'b1);
    chk1("rst_drive", oLCD_DataDrive, 1'b0);
    chk8("rst_data", oData, 8'h00);
    chk1("rst_valid", oValid, 1'b0);
    chk1("rst_ready", ready, 1'b1);
    step();
    Reset = 1'b0;
    step();

    // Busy/address read, then data read, then sample-window read.
    run_txn(1'b0, 4'h8, 4'h3, 1'b0, 1'b0, 1'b0);
    run_txn(1'b1, 4'h4, 4'h1, 1'b0, 1'b0, 1'b0);
    run_txn(1'b0, 4'h2, 4'h9, 1'b1, 1'b0, 1'b0);

    // Request/iRS noise while busy, iRead held so the next read chains at cycle 82.
    run_txn(1'b1, 4'h6, 4'hC, 1'b0, 1'b1, 1'b1);
    run_txn(1'b0, 4'h7, 4'hE, 1'b0, 1'b0, 1'b0);
    chk1("sb_drained", exp_q.size() == 0, 1'b1);

    // Reset during MSN E-high (cycle 8).
    iRead     = 1'b1;
    iRS       = 1'b1;
    iLCD_Data = 4'hB;
    for (int c = 1; c <= 8; c++) begin
      step();
      iRead = 1'b0;
      chk1("pre_rst_enable", oLCD_Enabled, c >= 3);
      chk1("pre_rst_rs", oLCD_RS, 1'b1);
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk1("mid_rst_enable", oLCD_Enabled, 1'b0);
    chk1("mid_rst_ready", ready, 1'b1);
    chk8("mid_rst_data", oData, 8'h00);
    chk1("mid_rst_valid", oValid, 1'b0);
    chk1("mid_rst_rs", oLCD_RS, 1'b0);
    for (int c = 0; c < 100; c++) begin
      step();
      chk1("quiet_valid", oValid, 1'b0);
      chk1("quiet_enable", oLCD_Enabled, 1'b0);
      chk1("quiet_ready", ready, 1'b1);
    end
    run_txn(1'b0, 4'hA, 4'h5, 1'b0, 1'b0, 1'b0);
    chk1("sb_final_drained", exp_q.size() == 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
